// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_ctrl_pkg
// Brief   : Shared encodings for the multi-cycle RISC-V control unit.
//           HALT state exists only when ILLEGAL_TRAP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
`else
    S_JAL      = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module  : alu_decoder
// Brief   : Maps alu_op and instruction function fields to the ALU select.
// Revision: 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_sel
);

  always_comb begin
    alu_sel = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_sel = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) may subtract; addi ignores instr[30].
          3'b000:  alu_sel = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_sel = ALU_SLT;
          3'b110:  alu_sel = ALU_OR;
          3'b111:  alu_sel = ALU_AND;
          default: alu_sel = ALU_ADD;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control
// Brief   : Multi-cycle RISC-V control FSM driving datapath selects/strobes.
//           Optional ILLEGAL_TRAP_EN: unknown opcodes trap into HALT.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] alu_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  localparam logic [1:0] c_LAT_LAST = 2'(MEM_LAT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_lat_cnt;
  logic       w_lat_done;
  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;

  assign w_lat_done = (r_lat_cnt == c_LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_lat_cnt <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_lat_cnt <= 2'd0;
      end else if (r_state == S_FETCH || r_state == S_MEMREAD) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_alu_op     = ALUOP_ADD;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    result_src   = RES_ALUOUT;
    adr_src      = ADR_PC;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (w_lat_done) begin
          w_ir_write   = 1'b1;
          w_pc_update  = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into the ALU output register.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_R:         w_state_next = S_EXECUTER;
          OP_I:         w_state_next = S_EXECUTEI;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_JAL:       w_state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      w_state_next = S_HALT;
`else
          default:      w_state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_IMM;
        w_state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = ADR_RESULT;
        if (w_lat_done) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_MEMDATA;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src      = ADR_RESULT;
        w_mem_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a    = SRCA_RS1;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a    = SRCA_RS1;
        w_alu_op     = ALUOP_SUB;
        w_branch     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        w_pc_update  = 1'b1;
        w_state_next = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: w_state_next = S_HALT;
`endif
      default: w_state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (w_alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (opcode[5]),
    .alu_sel  (alu_sel)
  );

  // Gate strobes with rst so nothing writes while the reset FETCH is held.
  assign ir_write  = w_ir_write & ~rst;
  assign pc_write  = (w_pc_update | (w_branch & zero)) & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign mem_write = w_mem_write & ~rst;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle RISC-V control unit; the producer side of the ALU `sel` interface.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives datapath mux selects, write strobes and the 3-bit ALU select.
- Sits between the instruction register (opcode/funct fields) and the datapath (PC, IR, regfile, memory, ALU).

Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal 1..4); FETCH and MEMREAD are each held MEM_LAT cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- alu_sel  out  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 101 slt
- alu_src_a  out  2  00 pc, 01 old_pc, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 alu_out reg, 01 mem data reg, 10 alu result
- adr_src  out  1  0 pc, 1 result
- ir_write, pc_write, reg_write, mem_write  out  1 each  write strobes
- illegal  out  1  see Optional Feature

Behaviour:
- Moore FSM plus a 2-bit latency counter; state register and counter reset asynchronously to FETCH and 0.
- All strobes (pc_write, ir_write, reg_write, mem_write) forced to 0 while rst=1.
- Unlisted outputs are 0 in every state.
- FETCH: a=00, b=10, alu_op=00, result_src=10, adr_src=0.
  - ir_write=1 and pc_update=1 only on the final (MEM_LAT-th) cycle.
  - Then DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> FETCH
- MEMADR: a=10, b=01, alu_op=00. Next: opcode[5]=0 -> MEMREAD, 1 -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Held MEM_LAT cycles, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXECUTER: a=10, b=00, alu_op=10. Next: ALUWB.
- EXECUTEI: a=10, b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.
- pc_write = pc_update | (branch & zero); combinational from zero in BEQ.
- ALU decode (combinational, from alu_op):
  - 00 -> 000; 01 -> 001.
  - 10 and funct3=000 -> 001 if (funct7b5 & opcode[5]), else 000.
  - 10 and funct3=010 -> 101; 110 -> 011; 111 -> 010.
  - 10 and any other funct3 -> 000.
- Latency counter: cleared on every state change; advances only in FETCH/MEMREAD.
  - MEM_LAT=1: counter unused; single-cycle states.
- Instruction cycle counts:
  - MEM_LAT=1: lw 5, sw 4, R/I 4, beq 3, jal 4.
  - Each extra MEM_LAT cycle adds 1 to every instruction (2 to lw).
- rst asserted mid-instruction: immediate return to FETCH, counter 0, no strobes. First fetch starts the cycle after rst deasserts.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> HALT state.
  - HALT drives illegal=1, all strobes 0, alu_sel=000; stays there until rst.
- Undefined:
  - No HALT state; unknown opcode returns to FETCH (instruction treated as nop).
  - illegal tied to 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding constants (4-bit)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - alu_sel constants (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101)
  - alu_op constants
  - mux select constants
- Sub-module alu_decoder: combinational alu_op/funct3/funct7b5/opcode[5] -> alu_sel.

Test Plan:
- Reset mid-MEMREAD (lw, MEM_LAT=2) -> next cycle state FETCH, all strobes 0. After release: ir_write=1 on 2nd FETCH cycle.
- R-type sub (opcode 0110011, funct3 000, funct7b5 1), MEM_LAT=1 -> 4 cycles; alu_sel=001 in EXECUTER; reg_write=1 only in ALUWB.
- addi with funct7b5=1 (opcode 0010011) -> alu_sel=000. slt (funct3 010) -> 101. or -> 011. and -> 010.
- lw, MEM_LAT=3:
  - ir_write pulses once at cycle 3.
  - MEMREAD held 3 cycles; reg_write with result_src=01 one cycle.
  - Total 9 cycles.
- beq with zero=1 -> pc_write=1 in BEQ, alu_sel=001. zero=0 -> pc_write=0. Both take 3 cycles.
- Opcode 1111111:
  - With ILLEGAL_TRAP_EN: illegal=1 from cycle after DECODE, held; strobes 0.
  - Without: back to FETCH, illegal=0.
